// File: rtl/envelope_pkg.sv
// Shared stage encoding and parameter defaults for the ADSR envelope generator.
package envelope_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_stage_t;

  localparam int unsigned LVL_W_DEF    = 8;
  localparam int unsigned TICK_DIV_DEF = 500000;

endpackage

// File: rtl/envelope_generator_prescaler.sv
// Free-running envelope step divider: one-cycle tick every TICK_DIV clocks.
module env_prescaler
  import envelope_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q is precomputed so it is high exactly while the count sits at LAST
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/envelope_generator.sv
// Key-gated ADSR amplitude envelope with programmable rates and a scaled output multiply.
// Build option: ENV_EXP_RELEASE_EN selects an exponential-style release step.
module envelope_generator
  import envelope_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned LVL_W    = LVL_W_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gate,
  input  logic [W-1:0]     sample_in,
  input  logic [LVL_W-1:0] attack_rate,
  input  logic [LVL_W-1:0] decay_rate,
  input  logic [LVL_W-1:0] release_rate,
  input  logic [LVL_W-1:0] sustain_level,
  output logic [W-1:0]     sample_out,
  output logic [2:0]       stage,
  output logic             busy
);

  localparam int unsigned EXT_W  = LVL_W + 1;
  localparam int unsigned PROD_W = W + LVL_W;
  localparam logic [LVL_W-1:0] LMAX = '1;

  env_stage_t       stage_q, stage_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             busy_q;
  logic [W-1:0]     sample_q, sample_d;
  logic             tick;

  logic [EXT_W-1:0]  lvl_ext_c, atk_sum_c, dec_dif_c, rel_step_c, rel_dif_c;
  logic              rel_instant_c;
  logic [PROD_W-1:0] prod_c;

  env_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // One extra bit so overflow and underflow show up as the MSB before saturation
  assign lvl_ext_c = {1'b0, level_q};
  assign atk_sum_c = lvl_ext_c + {1'b0, attack_rate};
  assign dec_dif_c = lvl_ext_c - {1'b0, decay_rate};

`ifdef ENV_EXP_RELEASE_EN
  logic [LVL_W-1:0] rel_shift_c;
  logic             unused_rel_hi_c;
  assign rel_shift_c     = level_q >> release_rate[2:0];
  assign rel_step_c      = (rel_shift_c == '0) ? EXT_W'(1) : {1'b0, rel_shift_c};
  assign rel_instant_c   = 1'b0;
  assign unused_rel_hi_c = ^release_rate[LVL_W-1:3];
`else
  assign rel_step_c    = {1'b0, release_rate};
  assign rel_instant_c = (release_rate == '0);
`endif

  assign rel_dif_c = lvl_ext_c - rel_step_c;

  // Gate changes win over ticks; the level only moves on a tick with no gate transition
  always_comb begin
    stage_d = stage_q;
    level_d = level_q;
    case (stage_q)
      ENV_IDLE: begin
        level_d = '0;
        if (gate) stage_d = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (!gate) begin
          stage_d = ENV_RELEASE;
        end else if (tick) begin
          if ((attack_rate == '0) || (atk_sum_c >= {1'b0, LMAX})) begin
            level_d = LMAX;
            stage_d = ENV_DECAY;
          end else begin
            level_d = atk_sum_c[LVL_W-1:0];
          end
        end
      end
      ENV_DECAY: begin
        if (!gate) begin
          stage_d = ENV_RELEASE;
        end else if (tick) begin
          if ((decay_rate == '0) || dec_dif_c[LVL_W] ||
              (dec_dif_c <= {1'b0, sustain_level})) begin
            level_d = sustain_level;
            stage_d = ENV_SUSTAIN;
          end else begin
            level_d = dec_dif_c[LVL_W-1:0];
          end
        end
      end
      ENV_SUSTAIN: begin
        if (!gate) begin
          stage_d = ENV_RELEASE;
        end else if (tick) begin
          level_d = sustain_level;
        end
      end
      ENV_RELEASE: begin
        if (gate) begin
          stage_d = ENV_ATTACK;
        end else if (tick) begin
          if (rel_instant_c || rel_dif_c[LVL_W] || (rel_dif_c[LVL_W-1:0] == '0)) begin
            level_d = '0;
            stage_d = ENV_IDLE;
          end else begin
            level_d = rel_dif_c[LVL_W-1:0];
          end
        end
      end
      default: begin
        stage_d = ENV_IDLE;
        level_d = '0;
      end
    endcase
  end

  assign prod_c   = PROD_W'(sample_in) * PROD_W'(level_q);
  assign sample_d = W'(prod_c >> LVL_W);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q  <= ENV_IDLE;
      level_q  <= '0;
      busy_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      stage_q  <= stage_d;
      level_q  <= level_d;
      busy_q   <= (stage_d != ENV_IDLE);
      sample_q <= sample_d;
    end
  end

  assign stage      = stage_q;
  assign busy       = busy_q;
  assign sample_out = sample_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Self-checking bench for envelope_generator: ADSR behavioural model plus directed literal checks.
module tb_envelope_generator;

  localparam int TICK_DIV = 4;
  localparam int LMAX     = 255;
  localparam int S_IDLE = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       gate;
  logic [7:0] sample_in;
  logic [7:0] attack_rate, decay_rate, release_rate, sustain_level;
  logic [7:0] sample_out;
  logic [2:0] stage;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_stage = 0, m_lvl = 0, m_cnt = 0, m_sout = 0, m_ticks = 0;
  int n_stg, n_lvl, n_step;
  bit n_tick;

  envelope_generator #(
    .W        (8),
    .LVL_W    (8),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .gate          (gate),
    .sample_in     (sample_in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .release_rate  (release_rate),
    .sustain_level (sustain_level),
    .sample_out    (sample_out),
    .stage         (stage),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADSR rules in plain integer arithmetic, evaluated on each rising edge
  always @(posedge clk) begin
    if (!reset_n) begin
      m_stage <= S_IDLE;
      m_lvl   <= 0;
      m_cnt   <= 0;
      m_sout  <= 0;
    end else begin
      n_stg  = m_stage;
      n_lvl  = m_lvl;
      n_tick = (m_cnt == TICK_DIV - 1);
      if (gate && (n_stg == S_IDLE || n_stg == S_REL)) begin
        n_stg = S_ATK;
      end else if (!gate && (n_stg == S_ATK || n_stg == S_DEC || n_stg == S_SUS)) begin
        n_stg = S_REL;
      end else if (n_tick) begin
        case (n_stg)
          S_ATK: begin
            n_lvl = (attack_rate == 0) ? LMAX : n_lvl + int'(attack_rate);
            if (n_lvl >= LMAX) begin n_lvl = LMAX; n_stg = S_DEC; end
          end
          S_DEC: begin
            if (decay_rate == 0 || n_lvl - int'(decay_rate) <= int'(sustain_level)) begin
              n_lvl = int'(sustain_level);
              n_stg = S_SUS;
            end else begin
              n_lvl = n_lvl - int'(decay_rate);
            end
          end
          S_SUS: n_lvl = int'(sustain_level);
          S_REL: begin
`ifdef ENV_EXP_RELEASE_EN
            n_step = n_lvl / (1 << (int'(release_rate) % 8));
            if (n_step < 1) n_step = 1;
`else
            n_step = (release_rate == 0) ? LMAX + 1 : int'(release_rate);
`endif
            n_lvl = n_lvl - n_step;
            if (n_lvl <= 0) begin n_lvl = 0; n_stg = S_IDLE; end
          end
          default: n_lvl = 0;
        endcase
      end
      m_sout  <= (int'(sample_in) * m_lvl) / 256;
      m_stage <= n_stg;
      m_lvl   <= n_lvl;
      m_cnt   <= n_tick ? 0 : m_cnt + 1;
      if (n_tick) m_ticks <= m_ticks + 1;
    end
  end

  // Continuous comparison of every registered output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stage", int'(stage), m_stage);
      chk("busy", int'(busy), (m_stage != S_IDLE) ? 1 : 0);
      chk("sample_out", int'(sample_out), m_sout);
    end
  end

  task automatic wait_ticks(input int n);
    int start;
    start = m_ticks;
    for (int i = 0; i < 16 * TICK_DIV * n && m_ticks < start + n; i++) @(negedge clk);
    if (m_ticks < start + n) chk("tick_wait_timeout", m_ticks - start, n);
  endtask

  task automatic wait_stage(input int s);
    for (int i = 0; i < 40 * TICK_DIV && m_stage != s; i++) @(negedge clk);
    chk("wait_stage", m_stage, s);
  endtask

  task automatic wait_pre_tick();
    for (int i = 0; i < 2 * TICK_DIV && m_cnt != TICK_DIV - 1; i++) @(negedge clk);
  endtask

  // After the next tick: pin the model level and DUT stage, then the output one clock later
  task automatic tick_chk(input string nm, input int lvl, input int stg, input int sout);
    wait_ticks(1);
    chk({nm, "_level"}, m_lvl, lvl);
    chk({nm, "_stage"}, int'(stage), stg);
    @(negedge clk);
    chk({nm, "_sample"}, int'(sample_out), sout);
  endtask

`ifdef ENV_EXP_RELEASE_EN
  localparam int REL1 = 96,  REL1_S = 75,  RETRIG = 160, RETRIG_S = 125;
`else
  localparam int REL1 = 78,  REL1_S = 60,  RETRIG = 142, RETRIG_S = 110;
`endif

  initial begin
    reset_n       = 1'b0;
    gate          = 1'b1;
    sample_in     = 8'd200;
    attack_rate   = 8'd64;
    decay_rate    = 8'd100;
    release_rate  = 8'd50;
    sustain_level = 8'd128;

    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_sample", int'(sample_out), 0);
    chk("reset_stage", int'(stage), S_IDLE);
    chk("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_stage", int'(stage), S_ATK);
    chk("post_reset_busy", int'(busy), 1);

    // Attack ramp and decay into sustain
    tick_chk("atk1", 64, S_ATK, 50);
    tick_chk("atk2", 128, S_ATK, 100);
    tick_chk("atk3", 192, S_ATK, 150);
    tick_chk("atk4", 255, S_DEC, 199);
    tick_chk("dec1", 155, S_DEC, 121);
    tick_chk("dec2", 128, S_SUS, 100);
    sustain_level = 8'd90;
    tick_chk("sus90", 90, S_SUS, 70);
    sustain_level = 8'd128;
    tick_chk("sus128", 128, S_SUS, 100);

    // Release then retrigger from the current level
    gate = 1'b0;
    @(negedge clk);
    chk("rel_entry_stage", int'(stage), S_REL);
    tick_chk("rel1", REL1, S_REL, REL1_S);
    gate = 1'b1;
    @(negedge clk);
    chk("retrig_stage", int'(stage), S_ATK);
    tick_chk("retrig", RETRIG, S_ATK, RETRIG_S);
    wait_stage(S_SUS);
    chk("resustain_level", m_lvl, 128);

    // Release all the way to idle
    gate = 1'b0;
`ifdef ENV_EXP_RELEASE_EN
    release_rate = 8'd1;
    begin
      int exp_rel[8] = '{64, 32, 16, 8, 4, 2, 1, 0};
      foreach (exp_rel[k]) begin
        wait_ticks(1);
        chk("exp_rel_level", m_lvl, exp_rel[k]);
      end
    end
    chk("exp_rel_idle_stage", int'(stage), S_IDLE);
    @(negedge clk);
    chk("exp_rel_idle_sample", int'(sample_out), 0);
`else
    tick_chk("rel_a", 78, S_REL, 60);
    tick_chk("rel_b", 28, S_REL, 21);
    tick_chk("rel_c", 0, S_IDLE, 0);
    chk("rel_idle_busy", int'(busy), 0);
`endif

    // Instantaneous attack
    release_rate = 8'd50;
    attack_rate  = 8'd0;
    gate         = 1'b1;
    tick_chk("atk0", 255, S_DEC, 199);
    wait_stage(S_SUS);
    chk("atk0_sustain_level", m_lvl, 128);

    // Gate edges landing on tick cycles must not step the level
    wait_pre_tick();
    chk("align_release", m_cnt, TICK_DIV - 1);
    gate = 1'b0;
    @(negedge clk);
    chk("coinc_rel_stage", int'(stage), S_REL);
    chk("coinc_rel_level", m_lvl, 128);
    @(negedge clk);
    chk("coinc_rel_sample", int'(sample_out), 100);
    wait_pre_tick();
    chk("align_attack", m_cnt, TICK_DIV - 1);
    gate = 1'b1;
    @(negedge clk);
    chk("coinc_atk_stage", int'(stage), S_ATK);
    chk("coinc_atk_level", m_lvl, 128);
    @(negedge clk);
    chk("coinc_atk_sample", int'(sample_out), 100);
    tick_chk("atk0b", 255, S_DEC, 199);

    // Reset mid-envelope aborts without a release
    reset_n = 1'b0;
    gate    = 1'b0;
    @(negedge clk);
    chk("midreset_stage", int'(stage), S_IDLE);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_sample", int'(sample_out), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("after_midreset_stage", int'(stage), S_IDLE);

    // Mixed traffic, checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      sample_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      if ($urandom_range(0, 15) == 0) begin
        attack_rate   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 90));
        decay_rate    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 90));
        release_rate  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 90));
        sustain_level = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom_range(0, 254));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
- Parametrised ADSR (attack/decay/sustain/release) amplitude envelope for the keyboard voice path; the successor to the fixed shift-based attenuator.
- Sits between the SPI sample source and the DAC output.
- Replaces hard-coded 0.5 s shift ramps with a key-gated state machine, runtime-programmable rates and sustain level, and a true scaled multiply.
- Retrigger from the current level; no clicks.

Parameters:
- W, 8, sample width (unsigned) of sample_in/sample_out
- LVL_W, 8, envelope level width; full scale LMAX = 2^LVL_W-1
- TICK_DIV, 500000, clk cycles per envelope step tick (>=2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- gate  in  1  key pressed (level-sensitive, already synchronised to clk)
- sample_in  in  W  unsigned audio sample
- attack_rate  in  LVL_W  level increment per tick in ATTACK; 0 = instantaneous
- decay_rate  in  LVL_W  level decrement per tick in DECAY; 0 = instantaneous
- release_rate  in  LVL_W  level decrement per tick in RELEASE; 0 = instantaneous
- sustain_level  in  LVL_W  hold level in SUSTAIN
- sample_out  out  W  enveloped sample, registered
- stage  out  3  current env_stage_t
- busy  out  1  stage != IDLE

Behaviour:
- Reset: one clock, synchronous, active-low. While reset_n=0 at a clk edge: stage=IDLE, level=0, prescaler=0, sample_out=0, busy=0. Reset mid-envelope aborts immediately with no release.
- Prescaler: free-running 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. Not reset by gate.
- Gate-driven transitions, evaluated every cycle, take priority over ticks:
  - gate=1 in IDLE or RELEASE -> ATTACK; level kept (retrigger from current level).
  - gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - In the cycle a gate-driven transition occurs, level is not stepped even if tick=1.
- Tick-driven steps, rates zero-extended; all arithmetic is done at LVL_W+1 bits, then saturated:
  - ATTACK: level = min(level+attack_rate, LMAX). On reaching LMAX -> DECAY.
  - DECAY: if level-decay_rate <= sustain_level, level = sustain_level and -> SUSTAIN; else level -= decay_rate. If sustain_level >= LMAX, DECAY exits to SUSTAIN on its first tick.
  - SUSTAIN: level tracks sustain_level on every tick, so a runtime change applies at the next tick. Stays in SUSTAIN while gate=1.
  - RELEASE: level = max(level-release_rate, 0). On reaching 0 -> IDLE.
  - IDLE: level held at 0.
- Rate 0 means instantaneous: on the next tick, ATTACK sets level to LMAX, DECAY to sustain_level, RELEASE to 0, then the normal exit transition fires.
- Output: sample_out = (sample_in * level) >> LVL_W, using a full W+LVL_W-bit product, registered.
  - Latency is 1 cycle from sample_in or level change.
  - At level=LMAX, sample_out = sample_in - 1 for sample_in>0; this is accepted.
- stage and busy are registered and update in the same cycle as the state register.

Optional Feature:
- Macro ENV_EXP_RELEASE_EN.
  - Defined: RELEASE step becomes level -= max(level >> release_rate[2:0], 1), an exponential-style decay, with the same exit at 0. release_rate[LVL_W-1:3] is ignored, and rate-0 instantaneous behaviour does not apply to RELEASE.
  - Undefined: linear release as above.
- Attack and decay are unaffected in both builds.

Decomposition:
- Shared package envelope_pkg:
  - typedef enum logic [2:0] env_stage_t {ENV_IDLE=0, ENV_ATTACK=1, ENV_DECAY=2, ENV_SUSTAIN=3, ENV_RELEASE=4}
  - localparam defaults for LVL_W and TICK_DIV
- Sub-module env_prescaler (parameter TICK_DIV; ports clk, reset_n, tick) holds the tick divider.
- The FSM, level arithmetic and output multiply live in envelope_generator.

Test Plan:
Common setup: W=8, LVL_W=8, TICK_DIV=4, sample_in=200.
- Reset: reset_n=0 for 3 clks with gate=1 -> sample_out=0, stage=IDLE, busy=0; after release of reset and 1 clk, stage=ATTACK.
- Attack: gate=1, attack_rate=64 -> level 64,128,192,255 on ticks 1-4, stage=DECAY after tick 4; at level 128, sample_out=100 one clk later.
- Decay/sustain: decay_rate=100, sustain_level=128 -> level 255->155->128, stage=SUSTAIN; change sustain_level to 90 -> level=90 at next tick.
- Release and retrigger: from sustain 128, gate=0, release_rate=50 -> level 78, then gate=1 -> ATTACK from 78, next tick 142.
- Release to idle: release_rate=50 from 128 -> 78, 28, 0 -> stage=IDLE, busy=0, sample_out=0.
- Boundaries:
  - attack_rate=0 -> LMAX on first tick.
  - gate toggle coincident with tick -> no level step that cycle.
  - ENV_EXP_RELEASE_EN with release_rate=1 from 128 -> 64, 32, 16, 8, 4, 2, 1, 0.
